// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_BUS_W = 16;
    localparam int unsigned WAIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the CPU MEM stage and the responder.
interface dmem_if;

    logic                            req_valid;
    logic                            req_write;
    logic [dmem_pkg::ADDR_BUS_W-1:0] req_addr;
    logic [dmem_pkg::DATA_W-1:0]     req_wdata;
    logic                            req_ready;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [dmem_pkg::DATA_W-1:0]     rsp_rdata;
    logic                            rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port and one registered, read-before-write read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              acc_en,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[addr] <= wdata;
        end
    end

    // Non-loads and rejected accesses return zero on the access edge.
    always_comb begin
        rdata_d = rdata_q;
        if (acc_en) begin
            rdata_d = rd_en ? mem_q[addr] : '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Stalling data-memory responder: accepts one request, waits WAIT_CYCLES, accesses the array, responds.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic   Clk,
    input  logic   Rst,
    dmem_if.slave  bus,
    output logic   busy
);

    state_e                  state_q,     state_d;
    logic [WAIT_W-1:0]       wait_cnt_q,  wait_cnt_d;
    logic                    lat_write_q, lat_write_d;
    logic [ADDR_BUS_W-1:0]   lat_addr_q,  lat_addr_d;
    logic [DATA_W-1:0]       lat_wdata_q, lat_wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q,   rsp_err_d;

    logic                    acc_en;
    logic                    in_range;
    logic                    wr_en;
    logic                    rd_en;
    logic [DATA_W-1:0]       arr_rdata;

    // Any address bit above the implemented array marks the access out of range.
    assign in_range = ((lat_addr_q >> ADDR_W) == '0);
    assign wr_en    = acc_en & lat_write_q & in_range;
    assign rd_en    = ~lat_write_q & in_range;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lat_write_d = lat_write_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        acc_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_write_d = bus.req_write;
                    lat_addr_d  = bus.req_addr;
                    lat_wdata_d = bus.req_wdata;
                    wait_cnt_d  = WAIT_W'(WAIT_CYCLES);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    acc_en      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~in_range;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d  = wait_cnt_q - WAIT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_write_q <= lat_write_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .Clk    (Clk),
        .Rst    (Rst),
        .acc_en (acc_en),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (lat_addr_q[ADDR_W-1:0]),
        .wdata  (lat_wdata_q),
        .rdata  (arr_rdata)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_CYCLES=0 (index 0), one with 2 (index 1).
module tb_dmem_responder;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    dmem_if bus0 ();
    dmem_if bus2 ();
    logic   busy0, busy2;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Rst(Rst), .bus(bus0), .busy(busy0)
    );
    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut2 (
        .Clk(Clk), .Rst(Rst), .bus(bus2), .busy(busy2)
    );

    logic        rv [2];
    logic        rw [2];
    logic        rr [2];
    logic [15:0] ra [2];
    logic [15:0] rd [2];
    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic        bsy [2];
    logic [15:0] rdat [2];

    assign bus0.req_valid = rv[0];
    assign bus0.req_write = rw[0];
    assign bus0.req_addr  = ra[0];
    assign bus0.req_wdata = rd[0];
    assign bus0.rsp_ready = rr[0];
    assign bus2.req_valid = rv[1];
    assign bus2.req_write = rw[1];
    assign bus2.req_addr  = ra[1];
    assign bus2.req_wdata = rd[1];
    assign bus2.rsp_ready = rr[1];

    assign rdy[0]  = bus0.req_ready;
    assign vld[0]  = bus0.rsp_valid;
    assign err[0]  = bus0.rsp_err;
    assign rdat[0] = bus0.rsp_rdata;
    assign bsy[0]  = busy0;
    assign rdy[1]  = bus2.req_ready;
    assign vld[1]  = bus2.rsp_valid;
    assign err[1]  = bus2.rsp_err;
    assign rdat[1] = bus2.rsp_rdata;
    assign bsy[1]  = busy2;

    typedef struct {
        int          dut;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q [$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per response and checks data, error flag and latency.
    logic seen     [2];
    logic acc_pend [2];
    int   acc_cyc  [2];

    always @(negedge Clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!Rst) begin
                seen[i]     = 1'b0;
                acc_pend[i] = 1'b0;
            end else begin
                if (rv[i] && rdy[i]) begin
                    acc_cyc[i]  = cyc + 1;
                    acc_pend[i] = 1'b1;
                end
                if (vld[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL rsp_unexpected dut%0d: actual=rdata %0h required=no response", i, rdat[i]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_dut_order", 32'(i), 32'(e.dut));
                        chk("rsp_rdata", 32'(rdat[i]), 32'(e.rdata));
                        chk("rsp_err", 32'(err[i]), 32'(e.err));
                        chk("rsp_latency", acc_pend[i] ? 32'(cyc - acc_cyc[i]) : 32'hFFFF_FFFF,
                            (i == 0) ? 32'd1 : 32'd3);
                        acc_pend[i] = 1'b0;
                    end
                end
                if (!vld[i]) seen[i] = 1'b0;
            end
        end
    end

    // Drives one request from posedge+1 alignment; returns at posedge+1 after the accepting edge.
    task automatic issue(input int i, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] er, input logic ee, input logic push);
        int t;
        rv[i] = 1'b1;
        rw[i] = wr;
        ra[i] = a;
        rd[i] = d;
        if (push) exp_q.push_back('{i, er, ee});
        for (t = 0; t < 50; t++) begin
            @(negedge Clk);
            if (rdy[i]) break;
        end
        if (t == 50) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout dut%0d: actual=not accepted required=accepted", i);
        end
        @(posedge Clk);
        #1;
        rv[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int t;
        for (t = 0; t < 50; t++) begin
            @(negedge Clk);
            if (!bsy[i]) break;
        end
        if (t == 50) begin
            n_chk++;
            n_err++;
            $display("FAIL idle_timeout dut%0d: actual=busy required=idle", i);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic xact(input int i, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] er, input logic ee);
        issue(i, wr, a, d, er, ee, 1'b1);
        wait_idle(i);
    endtask

    task automatic chk_reset_outputs(input int i, input string tag);
        chk({tag, "_req_ready"}, 32'(rdy[i]), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(vld[i]), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rdat[i]), 32'd0);
        chk({tag, "_rsp_err"},   32'(err[i]), 32'd0);
        chk({tag, "_busy"},      32'(bsy[i]), 32'd0);
    endtask

    logic [15:0] shadow [256];
    int          acc_at [8];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0; rr[i] = 1'b1;
        end

        repeat (2) @(negedge Clk);
        chk_reset_outputs(0, "por_dut0");
        chk_reset_outputs(1, "por_dut2");
        @(posedge Clk);
        #1 Rst = 1'b1;

        // Reset mid-store: the pending 0xBEEF store must be discarded.
        xact(1, 1'b1, 16'h0005, 16'h1111, 16'h0000, 1'b0);
        issue(1, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        @(negedge Clk);
        chk("busy_in_wait", 32'(bsy[1]), 32'd1);
        #2 Rst = 1'b0;
        #1 chk_reset_outputs(1, "midrst");
        @(negedge Clk);
        chk_reset_outputs(1, "midrst_hold");
        @(posedge Clk);
        #1 Rst = 1'b1;
        xact(1, 1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0);

        // Store/load round trip with two wait states.
        xact(1, 1'b1, 16'h0010, 16'hA5A5, 16'h0000, 1'b0);
        xact(1, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 1'b0);

        // Zero wait states.
        xact(0, 1'b1, 16'h00FF, 16'h1234, 16'h0000, 1'b0);
        xact(0, 1'b0, 16'h00FF, 16'h0000, 16'h1234, 1'b0);

        // Out of range: 0x0100 aliases word 0 in the low bits, which must stay untouched.
        xact(1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        xact(1, 1'b1, 16'h0100, 16'hFFFF, 16'h0000, 1'b1);
        xact(1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
        xact(1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        // Back-pressure with an ignored store pulse aimed at the same word.
        rr[1] = 1'b0;
        issue(1, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 1'b0, 1'b1);
        begin
            int t;
            for (t = 0; t < 20; t++) begin
                @(negedge Clk);
                if (vld[1]) break;
            end
            if (t == 20) begin
                n_chk++;
                n_err++;
                $display("FAIL bp_rsp_timeout: actual=no rsp_valid required=rsp_valid");
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(vld[1]), 32'd1);
            chk("bp_rsp_rdata", 32'(rdat[1]), 32'hA5A5);
            chk("bp_req_ready", 32'(rdy[1]), 32'd0);
            @(posedge Clk);
            #1;
            if (k == 1) begin
                rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 16'h0010; rd[1] = 16'hDEAD;
            end
            if (k == 2) rv[1] = 1'b0;
            if (k < 4) @(negedge Clk);
        end
        rr[1] = 1'b1;
        @(negedge Clk);
        chk("bp_still_resp", 32'(vld[1]), 32'd1);
        @(posedge Clk);
        #1;
        chk("bp_release_busy", 32'(bsy[1]), 32'd0);
        chk("bp_release_valid", 32'(vld[1]), 32'd0);
        chk("bp_release_ready", 32'(rdy[1]), 32'd1);
        xact(1, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 1'b0);

        // Back-to-back: req_valid held high, alternating store/load per address.
        for (int n = 0; n < 8; n++) begin
            logic [15:0] a;
            a = 16'h0020 + 16'(n / 2);
            rw[1] = ((n % 2) == 0);
            ra[1] = a;
            rv[1] = 1'b1;
            if ((n % 2) == 0) begin
                rd[1]    = 16'($urandom);
                shadow[a[7:0]] = rd[1];
                exp_q.push_back('{1, 16'h0000, 1'b0});
            end else begin
                rd[1] = 16'($urandom);
                exp_q.push_back('{1, shadow[a[7:0]], 1'b0});
            end
            begin
                int t;
                for (t = 0; t < 50; t++) begin
                    @(negedge Clk);
                    if (rdy[1]) break;
                end
                if (t == 50) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL b2b_accept_timeout op%0d: actual=not accepted required=accepted", n);
                end
            end
            acc_at[n] = cyc + 1;
            @(posedge Clk);
            #1;
        end
        rv[1] = 1'b0;
        for (int n = 1; n < 8; n++) begin
            chk("b2b_accept_spacing", 32'(acc_at[n] - acc_at[n-1]), 32'd5);
        end
        wait_idle(1);

        repeat (3) @(negedge Clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipelined CPU's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs the access on an internal word array and returns read data and an error flag over a second valid/ready handshake. The block replaces the zero-latency data memory, so the CPU's MEM stage can be verified against a realistic, stalling memory.

## Interface
- ADDR_W, default 8: word-address bits implemented; the array holds 2^ADDR_W 16-bit words.
- WAIT_CYCLES, default 2: wait states between request acceptance and the array access; legal range is 0..15.

- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  the CPU presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  16  store data.
- req_ready  out  1  the responder can accept a request.
- rsp_valid  out  1  a response is pending.
- rsp_ready  in  1  the CPU accepts the response.
- rsp_rdata  out  16  load data; 0 for stores and for errors.
- rsp_err  out  1  the address is out of range.
- busy  out  1  the FSM is not in IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid & req_ready at the edge.
  - On acceptance, latch req_write/req_addr/req_wdata, load wait_cnt=WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0.
  - If wait_cnt==0 at the edge: perform the access and go to RESP.
  - Otherwise decrement wait_cnt.
- Access, performed on the WAIT→RESP edge:
  - Range check: if latched addr[15:ADDR_W]≠0, set rsp_err=1 and rsp_rdata=0, and suppress any write.
  - Store: write the array at addr[ADDR_W-1:0]; rsp_rdata=0.
  - Load: rsp_rdata = array contents before any same-edge write.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_valid & rsp_ready at the edge, go to IDLE.
  - The new request is not accepted in the same cycle; req_ready rises only in IDLE.
- Request inputs are ignored outside IDLE.
- busy = (state≠IDLE).
- Array contents are not cleared by reset; the CPU must store before it loads.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, wait_cnt=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - A pending store not yet on its access edge is discarded.
- Latency: for a request accepted at edge k, rsp_valid is high after edge k+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives a 1-cycle response.
- Minimum spacing between accepts: WAIT_CYCLES+3 cycles, when rsp_ready is held high.
- Back-pressure: rsp_valid stays high with data unchanged for any number of cycles while rsp_ready=0.
- rsp_ready while rsp_valid=0 has no effect.
- All outputs are registered except req_ready and busy, which are decoded from state.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - DATA_W=16;
  - WAIT_W=4, the width of wait_cnt.
- Sub-module dmem_array holds the storage:
  - parameter ADDR_W;
  - one synchronous write port;
  - one registered read port;
  - read-before-write on the same address.
- The top level contains the FSM, the request latch, the wait counter and the range check.

## Test plan
- Reset mid-store: accept a store to 0x0005 with data 0xBEEF, assert Rst during WAIT, then load 0x0005 after a prior store of 0x1111. Required: rsp_rdata=0x1111, and all outputs were at their reset values while Rst was low.
- Store/load round trip with WAIT_CYCLES=2:
  - Store 0xA5A5 to 0x0010, accepted at edge k. Required: rsp_valid after edge k+3, rsp_rdata=0, rsp_err=0.
  - Then load 0x0010. Required: rsp_rdata=0xA5A5.
- WAIT_CYCLES=0: store then load 0x00FF with data 0x1234. Required: each response is 1 cycle after acceptance, and the load returns 0x1234.
- Out of range with ADDR_W=8: store 0x0100 with data 0xFFFF, then load 0x0100 and load 0x0000 (previously 0x0000). Required: rsp_err=1 and rdata=0 for both 0x0100 accesses, and 0x0000 still reads 0x0000.
- Back-pressure:
  - Hold rsp_ready=0 for 5 cycles during a load response. Required: rsp_valid and rsp_rdata stay stable, req_ready=0, and a req_valid pulse is ignored.
  - Then raise rsp_ready. Required: IDLE on the next edge.
- Back-to-back traffic: issue 8 alternating stores and loads with random data, holding req_valid continuously. Required: exactly one accept per IDLE visit, responses in order, and loads matching a shadow model.
